// File: rtl/adder_issue_ctrl.sv
// adder_issue_ctrl: pairs two operand streams, feeds an external fixed-latency
// adder, and collects each sum into a small result FIFO. Issue is gated by
// credits so the FIFO can never overflow while the consumer stalls.
module adder_issue_ctrl #(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned ADD_LATENCY = 1,
   parameter int unsigned OUT_DEPTH   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_a1_valid,
   output logic             io_a1_ready,
   input  logic [WIDTH-1:0] io_a1_bits,
   input  logic             io_a2_valid,
   output logic             io_a2_ready,
   input  logic [WIDTH-1:0] io_a2_bits,
   output logic [WIDTH-1:0] add_a1,
   output logic [WIDTH-1:0] add_a2,
   input  logic [WIDTH-1:0] add_c,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_bits,
   output logic             io_busy
);

   localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
   localparam int unsigned CNT_W = $clog2(OUT_DEPTH + ADD_LATENCY + 1);

   logic                   a1_full_q, a1_full_d;
   logic                   a2_full_q, a2_full_d;
   logic [WIDTH-1:0]       a1_data_q, a1_data_d;
   logic [WIDTH-1:0]       a2_data_q, a2_data_d;
   logic [ADD_LATENCY-1:0] infl_q, infl_d;
   logic [WIDTH-1:0]       mem_q [OUT_DEPTH];
   logic [WIDTH-1:0]       mem_d [OUT_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic [CNT_W-1:0]       inflight_cnt;
   logic                   issue;
   logic                   a1_fire;
   logic                   a2_fire;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;

   // Credit check, handshakes and FIFO status
   always_comb begin
      inflight_cnt = CNT_W'($countones(infl_q));
      issue        = a1_full_q & a2_full_q &
                     ((count_q + inflight_cnt) < CNT_W'(OUT_DEPTH));
      io_a1_ready  = ~a1_full_q | issue;
      io_a2_ready  = ~a2_full_q | issue;
      a1_fire      = io_a1_valid & io_a1_ready;
      a2_fire      = io_a2_valid & io_a2_ready;
      push         = infl_q[ADD_LATENCY-1];
      io_out_valid = (count_q != '0);
      pop          = io_out_valid & io_out_ready;
      fifo_full    = (count_q == CNT_W'(OUT_DEPTH));
   end

   // Operand slots: reload on accept, clear on issue otherwise
   always_comb begin
      a1_full_d = a1_full_q;
      a2_full_d = a2_full_q;
      a1_data_d = a1_data_q;
      a2_data_d = a2_data_q;
      if (issue) begin
         a1_full_d = 1'b0;
         a2_full_d = 1'b0;
      end
      if (a1_fire) begin
         a1_full_d = 1'b1;
         a1_data_d = io_a1_bits;
      end
      if (a2_fire) begin
         a2_full_d = 1'b1;
         a2_data_d = io_a2_bits;
      end
   end

   // In-flight tag pipe mirrors the adder register depth
   always_comb begin
      infl_d = (infl_q << 1) | ADD_LATENCY'(issue);
   end

   // Result FIFO: tagged adder output is written at the end of its valid cycle
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = add_c;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         a1_full_q <= 1'b0;
         a2_full_q <= 1'b0;
         a1_data_q <= '0;
         a2_data_q <= '0;
         infl_q    <= '0;
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         a1_full_q <= a1_full_d;
         a2_full_q <= a2_full_d;
         a1_data_q <= a1_data_d;
         a2_data_q <= a2_data_d;
         infl_q    <= infl_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Adder operands are the slot contents; output is the FIFO head
   always_comb begin
      add_a1      = a1_data_q;
      add_a2      = a2_data_q;
      io_out_bits = mem_q[rd_ptr_q];
      io_busy     = a1_full_q | a2_full_q | (|infl_q) | (count_q != '0);
   end

   // The credit rule makes a push into a full FIFO impossible
   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
                                    !(push && fifo_full));

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Bench for adder_issue_ctrl: directed latency cases plus random traffic
// checked against an order-only queue model of operand pairing.
module tb_adder_issue_ctrl;

   localparam int unsigned W     = 64;
   localparam int unsigned LAT   = 1;
   localparam int unsigned DEPTH = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic         a1_valid, a1_ready, a2_valid, a2_ready;
   logic         out_valid, out_ready, busy;
   logic [W-1:0] a1_bits, a2_bits, add_a1, add_a2, add_c, out_bits;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Environment adder: LAT-deep unreset register pipe
   logic [W-1:0] add_pipe [LAT];
   always @(posedge clock) begin
      add_pipe[0] <= add_a1 + add_a2;
      for (int i = 1; i < int'(LAT); i++) add_pipe[i] <= add_pipe[i-1];
   end
   assign add_c = add_pipe[LAT-1];

   adder_issue_ctrl #(.WIDTH(W), .ADD_LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_a1_valid  (a1_valid),
      .io_a1_ready  (a1_ready),
      .io_a1_bits   (a1_bits),
      .io_a2_valid  (a2_valid),
      .io_a2_ready  (a2_ready),
      .io_a2_bits   (a2_bits),
      .add_a1       (add_a1),
      .add_a2       (add_a2),
      .add_c        (add_c),
      .io_out_valid (out_valid),
      .io_out_ready (out_ready),
      .io_out_bits  (out_bits),
      .io_busy      (busy)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: accepted operands pair in arrival order, sums leave in order
   logic [W-1:0] a1_q[$], a2_q[$], exp_q[$];
   int           pops = 0;
   int           pairs = 0;
   int           pop_cyc[$];
   logic [W-1:0] last_out = '0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] bits_prev = '0;

   always @(negedge clock) begin
      if (reset) begin
         a1_q.delete();
         a2_q.delete();
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_bits", out_bits, bits_prev);
         end
         if (out_valid && out_ready) begin
            pops++;
            pop_cyc.push_back(cyc);
            last_out = out_bits;
            if (exp_q.size() == 0) chk("spurious_out", W'(exp_q.size()), W'(1));
            else chk("out_order", out_bits, exp_q.pop_front());
         end
         stall_prev = out_valid && !out_ready;
         bits_prev  = out_bits;
         if (a1_valid && a1_ready) a1_q.push_back(a1_bits);
         if (a2_valid && a2_ready) a2_q.push_back(a2_bits);
         while (a1_q.size() > 0 && a2_q.size() > 0) begin
            exp_q.push_back(a1_q.pop_front() + a2_q.pop_front());
            pairs++;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   // Offer a pair, holding each channel until it is accepted
   task automatic send_pair(input logic [W-1:0] x, input logic [W-1:0] y);
      bit d1 = 0;
      bit d2 = 0;
      int n  = 0;
      a1_valid = 1'b1; a1_bits = x;
      a2_valid = 1'b1; a2_bits = y;
      while (!(d1 && d2)) begin
         @(negedge clock);
         if (a1_valid && a1_ready) d1 = 1;
         if (a2_valid && a2_ready) d2 = 1;
         @(posedge clock);
         #1;
         if (d1) a1_valid = 1'b0;
         if (d2) a2_valid = 1'b0;
         n++;
         if (n > 200) begin
            chk("send_timeout", W'(n), W'(0));
            a1_valid = 1'b0;
            a2_valid = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int pbase;
      int bubbles;

      reset = 1'b1; out_ready = 1'b0;
      a1_valid = 1'b0; a2_valid = 1'b0; a1_bits = '0; a2_bits = '0;
      repeat (3) step();
      mid();
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_bits", out_bits, W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_add_a1", add_a1, W'(0));
      chk("rst_add_a2", add_a2, W'(0));
      chk("rst_a1_ready", W'(a1_ready), W'(1));
      step();
      reset = 1'b0;

      // Single op: 5 + 7
      a1_valid = 1'b1; a1_bits = W'(5);
      a2_valid = 1'b1; a2_bits = W'(7);
      out_ready = 1'b1;
      mid();
      chk("single_ready", W'(a1_ready & a2_ready), W'(1));
      step(); a1_valid = 1'b0; a2_valid = 1'b0;
      mid();
      chk("single_add_a1", add_a1, W'(5));
      chk("single_add_a2", add_a2, W'(7));
      step(); mid();
      chk("single_no_bypass", W'(out_valid), W'(0));
      step(); mid();
      chk("single_valid_t3", W'(out_valid), W'(1));
      chk("single_bits_t3", out_bits, W'(12));
      step(); mid();
      chk("single_busy_t4", W'(busy), W'(0));

      // Skewed arrival with wraparound
      step();
      a1_valid = 1'b1; a1_bits = '1;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) a1_valid = 1'b0;
         if (k == 4) begin a2_valid = 1'b1; a2_bits = W'(1); end
         mid();
         chk("skew_a1_ready", W'(a1_ready), W'(0));
         chk("skew_no_out", W'(out_valid), W'(0));
      end
      step(); a2_valid = 1'b0;
      mid();
      chk("skew_issue_ready", W'(a1_ready), W'(1));
      chk("skew_add_a1", add_a1, '1);
      step(); mid();
      chk("skew_t6_valid", W'(out_valid), W'(0));
      step(); mid();
      chk("skew_t7_valid", W'(out_valid), W'(1));
      chk("skew_t7_bits", out_bits, W'(0));
      step();

      // Streaming 16 pairs
      base = pops;
      pop_cyc.delete();
      for (int i = 0; i < 16; i++) send_pair(W'(i), W'(100 + i));
      repeat (6) step();
      chk("stream_count", W'(pops - base), W'(16));
      bubbles = 0;
      for (int i = 1; i < pop_cyc.size(); i++)
         if (pop_cyc[i] - pop_cyc[i-1] != 1) bubbles++;
      chk("stream_bubbles", W'(bubbles), W'(0));

      // Backpressure: 8 pairs into a stalled consumer
      out_ready = 1'b0;
      base  = pops;
      pbase = pairs;
      fork
         for (int i = 0; i < 8; i++) send_pair(W'(1000 + i), W'(2000 + 3 * i));
         begin
            repeat (20) step();
            mid();
            chk("bp_pairs_held", W'(pairs - pbase), W'(DEPTH + 1));
            chk("bp_a1_ready", W'(a1_ready), W'(0));
            chk("bp_a2_ready", W'(a2_ready), W'(0));
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_no_pops", W'(pops - base), W'(0));
            step();
            out_ready = 1'b1;
         end
      join
      repeat (12) step();
      chk("bp_delivered", W'(pops - base), W'(8));
      chk("bp_model_empty", W'(exp_q.size()), W'(0));

      // Random traffic: low then high consumer rate, many pointer laps
      base = pops;
      for (int k = 0; k < 600; k++) begin
         a1_valid  = 1'($urandom_range(0, 1));
         a2_valid  = 1'($urandom_range(0, 1));
         a1_bits   = {$urandom, $urandom};
         a2_bits   = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 99) < ((k < 300) ? 30 : 80));
         step();
      end
      a1_valid = 1'b0; a2_valid = 1'b0; out_ready = 1'b1;
      repeat (15) step();
      mid();
      chk("rand_laps", W'((pops - base) >= int'(3 * DEPTH)), W'(1));
      chk("rand_drained", W'(exp_q.size()), W'(0));
      chk("rand_busy", W'(busy), W'(a1_q.size() != 0 || a2_q.size() != 0));
      step();

      // Reset the cycle after an issue
      reset = 1'b1; step(); reset = 1'b0;
      send_pair(W'(40), W'(2));
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      base = pops;
      for (int k = 0; k < 6; k++) begin
         mid();
         chk("rst_mid_valid", W'(out_valid), W'(0));
         if (k == 0) chk("rst_mid_busy", W'(busy), W'(0));
         step();
      end
      send_pair(W'(2), W'(3));
      repeat (6) step();
      chk("rst_after_pops", W'(pops - base), W'(1));
      chk("rst_after_sum", last_out, W'(5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
